// File: rtl/pipe_pkg.sv
// Shared pipeline-boundary constants: bundle widths for each stage latch and
// the layout of the EX/MEM/WB control subfields inside a control bundle.
package pipe_pkg;

    localparam int IFID_CTRL_W  = 1;
    localparam int IFID_DATA_W  = 64;
    localparam int IDEX_CTRL_W  = 9;
    localparam int IDEX_DATA_W  = 111;
    localparam int EXMEM_CTRL_W = 5;
    localparam int EXMEM_DATA_W = 102;
    localparam int MEMWB_CTRL_W = 2;
    localparam int MEMWB_DATA_W = 69;

    // Control bundle layout, WB bits lowest so narrower stages keep a prefix.
    localparam int CTRL_WB_LSB  = 0;
    localparam int CTRL_WB_W    = 2;
    localparam int CTRL_MEM_LSB = 2;
    localparam int CTRL_MEM_W   = 3;
    localparam int CTRL_EX_LSB  = 5;
    localparam int CTRL_EX_W    = 4;

    typedef enum logic [1:0] {
        SRC_HOLD = 2'd0,
        SRC_SKID = 2'd1,
        SRC_IN   = 2'd2
    } main_src_e;

endpackage

// File: rtl/stage_slot.sv
// One {valid, ctrl, data} storage slot. Kill beats load beats drop; drop
// empties the slot and zeroes control while leaving the data bits untouched.
module stage_slot #(
    parameter int CTRL_W     = 9,
    parameter int DATA_W     = 111,
    parameter bit CLEAR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              kill,
    input  logic              load,
    input  logic              drop,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    logic              valid_r;
    logic [CTRL_W-1:0] ctrl_r;
    logic [DATA_W-1:0] data_r;

    // Slot storage with async reset to an empty, zeroed entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= 1'b0;
            ctrl_r  <= '0;
            data_r  <= '0;
        end else if (kill) begin
            valid_r <= 1'b0;
            ctrl_r  <= '0;
            if (CLEAR_DATA) begin
                data_r <= '0;
            end
        end else if (load) begin
            valid_r <= 1'b1;
            ctrl_r  <= ld_ctrl;
            data_r  <= ld_data;
        end else if (drop) begin
            valid_r <= 1'b0;
            ctrl_r  <= '0;
        end
    end

    assign valid = valid_r;
    assign ctrl  = ctrl_r;
    assign data  = data_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic registered pipeline boundary with valid/ready handshake, 1-entry
// skid buffer, synchronous flush and a saturating stall-cycle counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W     = IDEX_CTRL_W,
    parameter int DATA_W     = IDEX_DATA_W,
    parameter bit CLEAR_DATA = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              cnt_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              main_valid_s, skid_valid_s;
    logic [CTRL_W-1:0] main_ctrl_s, skid_ctrl_s, main_ld_ctrl_s;
    logic [DATA_W-1:0] main_data_s, skid_data_s, main_ld_data_s;
    logic              in_ready_s, acc_s, drn_s;
    logic              main_drop_s, skid_load_s, skid_drop_s;
    main_src_e         main_src_s;
    logic [CNT_W-1:0]  stall_cnt_r;

    // in_ready comes straight off the skid valid flop, so out_ready never reaches it.
    assign in_ready_s = ~skid_valid_s;
    assign acc_s      = in_valid & in_ready_s;
    assign drn_s      = main_valid_s & out_ready;

    // Decide what each slot does this cycle; flush is applied inside the slots.
    always_comb begin
        main_src_s  = SRC_HOLD;
        main_drop_s = 1'b0;
        skid_load_s = 1'b0;
        skid_drop_s = 1'b0;
        if (skid_valid_s) begin
            if (out_ready) begin
                main_src_s  = SRC_SKID;
                skid_drop_s = 1'b1;
            end else begin
                main_src_s  = SRC_HOLD;
            end
        end else if (acc_s) begin
            if (!main_valid_s || out_ready) begin
                main_src_s  = SRC_IN;
            end else begin
                skid_load_s = 1'b1;
            end
        end else if (drn_s) begin
            main_drop_s = 1'b1;
        end else begin
            main_src_s  = SRC_HOLD;
        end
    end

    // Main slot load source: the skid entry when refilling, otherwise upstream.
    always_comb begin
        main_ld_ctrl_s = in_ctrl;
        main_ld_data_s = in_data;
        case (main_src_s)
            SRC_SKID: begin
                main_ld_ctrl_s = skid_ctrl_s;
                main_ld_data_s = skid_data_s;
            end
            default: begin
                main_ld_ctrl_s = in_ctrl;
                main_ld_data_s = in_data;
            end
        endcase
    end

    stage_slot #(
        .CTRL_W     (CTRL_W),
        .DATA_W     (DATA_W),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .kill    (flush),
        .load    (main_src_s != SRC_HOLD),
        .drop    (main_drop_s),
        .ld_ctrl (main_ld_ctrl_s),
        .ld_data (main_ld_data_s),
        .valid   (main_valid_s),
        .ctrl    (main_ctrl_s),
        .data    (main_data_s)
    );

    stage_slot #(
        .CTRL_W     (CTRL_W),
        .DATA_W     (DATA_W),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .kill    (flush),
        .load    (skid_load_s),
        .drop    (skid_drop_s),
        .ld_ctrl (in_ctrl),
        .ld_data (in_data),
        .valid   (skid_valid_s),
        .ctrl    (skid_ctrl_s),
        .data    (skid_data_s)
    );

    // Stall counter: clear wins, otherwise saturating increment on a blocked output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= '0;
        end else if (cnt_clr) begin
            stall_cnt_r <= '0;
        end else if (main_valid_s && !out_ready && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = main_valid_s;
    assign out_ctrl  = main_ctrl_s;
    assign out_data  = main_data_s;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, streaming, back-pressure, flush,
// stall-counter saturation/clear and same-cycle drain/refill.
module tb_pipe_stage_reg;

    localparam int CTRL_W = 9;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;
    logic              cnt_clr;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_stage_reg #(
        .CTRL_W     (CTRL_W),
        .DATA_W     (DATA_W),
        .CLEAR_DATA (1'b1),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt),
        .cnt_clr   (cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        out_ready = 1'b0; cnt_clr = 1'b0;
        #2;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_ctrl !== 9'h000) begin n_bad++; $display("FAIL reset_out_ctrl got %h want 000", out_ctrl); end
        n_cmp++; if (out_data !== 16'h0000) begin n_bad++; $display("FAIL reset_out_data got %h want 0000", out_data); end
        n_cmp++; if (stall_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_streaming();
        logic [DATA_W-1:0] d;
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            d = 16'h1100 + 16'(i);
            send(9'(i), d);
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, in_ready); end
            tick();
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid[%0d] got %b want 1", i, out_valid); end
            n_cmp++; if (out_ctrl !== 9'(i)) begin n_bad++; $display("FAIL stream_ctrl[%0d] got %h want %h", i, out_ctrl, 9'(i)); end
            n_cmp++; if (out_data !== d) begin n_bad++; $display("FAIL stream_data[%0d] got %h want %h", i, out_data, d); end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_drained got %b want 0", out_valid); end
        n_cmp++; if (out_ctrl !== 9'h000) begin n_bad++; $display("FAIL stream_drained_ctrl got %h want 000", out_ctrl); end
        n_cmp++; if (stall_cnt !== 4'd0) begin n_bad++; $display("FAIL stream_no_stall got %0d want 0", stall_cnt); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        send(9'h00A, 16'hAAAA);
        tick();
        out_ready = 1'b0;
        send(9'h00B, 16'hBBBB);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_for_b got %b want 1", in_ready); end
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
        n_cmp++; if (out_ctrl !== 9'h00A) begin n_bad++; $display("FAIL bp_hold_a got %h want 00A", out_ctrl); end
        send(9'h00C, 16'hCCCC);
        tick();
        n_cmp++; if (out_ctrl !== 9'h00A) begin n_bad++; $display("FAIL bp_still_a got %h want 00A", out_ctrl); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_c_blocked got %b want 0", in_ready); end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_ctrl !== 9'h00B || out_data !== 16'hBBBB) begin
            n_bad++; $display("FAIL bp_out_b got v=%b c=%h d=%h want v=1 c=00B d=BBBB", out_valid, out_ctrl, out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_skid_freed got %b want 1", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_ctrl !== 9'h00C || out_data !== 16'hCCCC) begin
            n_bad++; $display("FAIL bp_out_c got v=%b c=%h d=%h want v=1 c=00C d=CCCC", out_valid, out_ctrl, out_data); end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty got %b want 0", out_valid); end
        n_cmp++; if (stall_cnt !== 4'd2) begin n_bad++; $display("FAIL bp_stall_cnt got %0d want 2", stall_cnt); end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        send(9'h0A1, 16'hA1A1);
        tick();
        out_ready = 1'b0;
        send(9'h0B2, 16'hB2B2);
        tick();
        send(9'h0C3, 16'hC3C3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got %b want 0", out_valid); end
        n_cmp++; if (out_ctrl !== 9'h000) begin n_bad++; $display("FAIL flush_ctrl got %h want 000", out_ctrl); end
        n_cmp++; if (out_data !== 16'h0000) begin n_bad++; $display("FAIL flush_data got %h want 0000", out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_c_dropped got %b want 0", out_valid); end
        n_cmp++; if (stall_cnt !== 4'd4) begin n_bad++; $display("FAIL flush_keeps_cnt got %0d want 4", stall_cnt); end
    endtask

    task automatic test_stall_counter();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        n_cmp++; if (stall_cnt !== 4'd0) begin n_bad++; $display("FAIL cnt_clear got %0d want 0", stall_cnt); end
        out_ready = 1'b1;
        send(9'h055, 16'h5555);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        n_cmp++; if (stall_cnt !== 4'd15) begin n_bad++; $display("FAIL cnt_saturate got %0d want 15", stall_cnt); end
        tick();
        n_cmp++; if (stall_cnt !== 4'd15) begin n_bad++; $display("FAIL cnt_hold_max got %0d want 15", stall_cnt); end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        n_cmp++; if (stall_cnt !== 4'd0) begin n_bad++; $display("FAIL cnt_clr_beats_stall got %0d want 0", stall_cnt); end
        tick();
        n_cmp++; if (stall_cnt !== 4'd1) begin n_bad++; $display("FAIL cnt_restart got %0d want 1", stall_cnt); end
        n_cmp++; if (out_ctrl !== 9'h055) begin n_bad++; $display("FAIL cnt_entry_held got %h want 055", out_ctrl); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_drain_refill();
        out_ready = 1'b1;
        send(9'h1A0, 16'h0A0A);
        tick();
        send(9'h1B0, 16'h0B0B);
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_ctrl !== 9'h1B0 || out_data !== 16'h0B0B) begin
            n_bad++; $display("FAIL refill_out_b got v=%b c=%h d=%h want v=1 c=1B0 d=0B0B", out_valid, out_ctrl, out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL refill_skid_empty got %b want 1", in_ready); end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL refill_no_dup got %b want 0", out_valid); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        send(9'h0D1, 16'hD1D1);
        tick();
        out_ready = 1'b0;
        send(9'h0D2, 16'hD2D2);
        tick();
        in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_full_before_reset got %b want 0", in_ready); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_reset_ready got %b want 1", in_ready); end
        n_cmp++; if (out_ctrl !== 9'h000) begin n_bad++; $display("FAIL mid_reset_ctrl got %h want 000", out_ctrl); end
        n_cmp++; if (stall_cnt !== 4'd0) begin n_bad++; $display("FAIL mid_reset_cnt got %0d want 0", stall_cnt); end
        rst = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_after_release got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_back_to_back();
        test_flush();
        test_stall_counter();
        test_drain_refill();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised, generic successor to the fixed-field ID/EX-style latch register, usable at any pipeline boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one control bundle and one data bundle through a registered stage.
- Uses a valid/ready handshake backed by a 1-entry skid buffer, so back-pressure never creates a combinational ready path.
- Supports synchronous flush (bubble insertion) with control zeroing, and a saturating stall-cycle counter for performance monitoring.

Parameters:
CTRL_W, 9, width of control bundle (EX+MEM+WB control bits); zeroed on flush and whenever the output is invalid
DATA_W, 111, width of data bundle (Rs/Rt/imm data plus Rs/Rt/Rd indices)
CLEAR_DATA, 0, 1 = also zero the data bundle on flush/reset-to-bubble; 0 = data bits hold (saves area)
CNT_W, 16, width of stall counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all held entries; same-cycle input is dropped
in_valid  input  1  upstream entry present
in_ready  output  1  stage can accept; registered (= ~skid_valid)
in_ctrl  input  CTRL_W  upstream control
in_data  input  DATA_W  upstream data
out_valid  output  1  main register holds a live entry
out_ready  input  1  downstream accepts this cycle
out_ctrl  output  CTRL_W  control; forced to 0 when out_valid=0
out_data  output  DATA_W  data
stall_cnt  output  CNT_W  saturating count of cycles with out_valid & ~out_ready
cnt_clr  input  1  synchronous clear of stall_cnt

Behaviour:
- Reset (rst=0, asynchronous): main_valid=0, skid_valid=0, all ctrl/data registers=0, stall_cnt=0. This gives out_valid=0, in_ready=1, out_ctrl=0, out_data=0.
- Storage: main register (drives outputs) and skid register; each holds {valid, ctrl, data}.
- Transfer definitions: acc = in_valid & in_ready; drn = out_valid & out_ready.
- Per-cycle update, in priority order:
  - flush=1: main_valid<=0 and skid_valid<=0; ctrl regs<=0; data regs<=0 only if CLEAR_DATA=1; acc is ignored. Flush wins over every other event.
  - skid_valid=1 & out_ready: main<=skid, skid_valid<=0. in_ready is 0 this cycle, so no input is accepted.
  - acc & (~main_valid | out_ready): main<={1,in_ctrl,in_data}.
  - acc & main_valid & ~out_ready: skid<={1,in_ctrl,in_data}; main holds.
  - drn & ~acc: main_valid<=0; ctrl<=0.
  - otherwise: hold.
- Latency: 1 cycle from acc to out_valid when empty. Throughput: 1 entry/cycle with out_ready held high.
- Ordering: strict FIFO. No entry is duplicated or lost except on flush.
- Full condition: main and skid both valid. in_ready=0 until the next drain.
- Stall counter:
  - cnt_clr=1 sets stall_cnt to 0 next cycle (priority over increment).
  - Otherwise increments when out_valid & ~out_ready.
  - Saturates at 2^CNT_W-1; no wrap.
  - Flush does not clear it.
- No combinational path from out_ready to in_ready.

Decomposition:
- Shared package pipe_pkg: CTRL_W/DATA_W constants per stage boundary (IFID, IDEX, EXMEM, MEMWB) and the bit offsets of the EX/MEM/WB control subfields.
- One natural sub-module, stage_slot: a {valid,ctrl,data} register with load/clear enables and async active-low reset. Instantiate it twice (main, skid).
- The handshake logic and stall counter stay in pipe_stage_reg.

Test Plan:
- Reset mid-stream: assert rst=0 while main and skid are both valid -> immediately out_valid=0, in_ready=1, out_ctrl=0, stall_cnt=0, without waiting for a clock edge.
- Streaming: out_ready=1; send ctrl 0x01..0x05 on consecutive cycles -> each appears 1 cycle later in order; in_ready stays 1.
- Back-pressure: send A,B,C with out_ready=0 from the cycle after A.
  - A held in main, B in skid; in_ready drops to 0; C is held upstream.
  - Raise out_ready -> outputs A, B, C on consecutive cycles; nothing lost.
- Flush with full buffer: main=A, skid=B, in_valid=1 carrying C, flush=1.
  - Next cycle out_valid=0, out_ctrl=0, in_ready=1; C is dropped.
  - With CLEAR_DATA=1, out_data=0 as well.
- Stall counter saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 and holds.
  - cnt_clr=1 -> 0 next cycle; cnt_clr together with a stall cycle -> 0.
- Drain then refill in the same cycle: main=A, out_ready=1, in_valid=1 carrying B -> next cycle out_valid=1 with B; skid stays empty.
